// File: rtl/exp5_pkg.sv
// Shared constants for the exp5 memory game: control-unit state codes
// and the default timeout behaviour.
package exp5_pkg;

    localparam logic [3:0] INICIAL       = 4'h0;
    localparam logic [3:0] PREPARACAO    = 4'h1;
    localparam logic [3:0] ESPERA_JOGADA = 4'h2;
    localparam logic [3:0] REGISTRA      = 4'h4;
    localparam logic [3:0] COMPARACAO    = 4'h5;
    localparam logic [3:0] PROXIMO       = 4'h6;
    localparam logic [3:0] FIM_ACERTO    = 4'hA;
    localparam logic [3:0] FIM_TIMEOUT   = 4'hD;
    localparam logic [3:0] FIM_ERRO      = 4'hE;

    localparam bit TIMEOUT_EN_DEFAULT = 1'b1;

endpackage

// File: rtl/exp5_unidade_controle.sv
// Moore control unit for the exp5 memory game: sequences 16 plays through
// the datapath and reports win, wrong play or timeout.
module exp5_unidade_controle
    import exp5_pkg::*;
#(
    parameter bit TIMEOUT_EN = TIMEOUT_EN_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       fimC,
    input  logic       fimT,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraT,
    output logic       contaT,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    logic [3:0] estado;
    logic [3:0] proximo_estado;

    always_ff @(posedge clock) begin
        if (reset)
            estado <= INICIAL;
        else
            estado <= proximo_estado;
    end

    // A play arriving together with the timer expiry takes priority.
    always_comb begin
        proximo_estado = INICIAL;
        case (estado)
            INICIAL:       proximo_estado = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:    proximo_estado = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (jogada_feita)
                    proximo_estado = REGISTRA;
                else if (fimT && TIMEOUT_EN)
                    proximo_estado = FIM_TIMEOUT;
                else
                    proximo_estado = ESPERA_JOGADA;
            end
            REGISTRA:      proximo_estado = COMPARACAO;
            COMPARACAO: begin
                if (!igual)
                    proximo_estado = FIM_ERRO;
                else if (fimC)
                    proximo_estado = FIM_ACERTO;
                else
                    proximo_estado = PROXIMO;
            end
            PROXIMO:       proximo_estado = ESPERA_JOGADA;
            FIM_ACERTO:    proximo_estado = iniciar ? PREPARACAO : FIM_ACERTO;
            FIM_ERRO:      proximo_estado = iniciar ? PREPARACAO : FIM_ERRO;
            FIM_TIMEOUT:   proximo_estado = iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:       proximo_estado = INICIAL;
        endcase
    end

    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraT     = 1'b0;
        contaT    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (estado)
            PREPARACAO: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
                zeraT = 1'b1;
            end
            ESPERA_JOGADA: contaT = 1'b1;
            REGISTRA:      registraR = 1'b1;
            PROXIMO: begin
                contaC = 1'b1;
                zeraT  = 1'b1;
            end
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_exp5_unidade_controle.sv
// Directed testbench for exp5_unidade_controle: win, error, timeout,
// simultaneous events, mid-game reset and restart.
module tb_exp5_unidade_controle;

    logic       clock = 1'b0;
    logic       reset, iniciar, jogada_feita, igual, fimC, fimT;
    logic       zeraC, contaC, zeraT, contaT, zeraR, registraR;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    logic       n_zeraC, n_contaC, n_zeraT, n_contaT, n_zeraR, n_registraR;
    logic       n_pronto, n_acertou, n_errou, n_timeout;
    logic [3:0] n_db_estado;

    int testsRun = 0;
    int testsFailed = 0;
    int countC = 0;
    int snapC;

    // Output vector order: zeraC contaC zeraT contaT zeraR registraR pronto acertou errou timeout
    localparam logic [9:0] OUT_NONE = 10'b00_0000_0000;
    localparam logic [9:0] OUT_PREP = 10'b10_1010_0000;
    localparam logic [9:0] OUT_ESP  = 10'b00_0100_0000;
    localparam logic [9:0] OUT_REG  = 10'b00_0001_0000;
    localparam logic [9:0] OUT_PROX = 10'b01_1000_0000;
    localparam logic [9:0] OUT_ACE  = 10'b00_0000_1100;
    localparam logic [9:0] OUT_ERR  = 10'b00_0000_1010;
    localparam logic [9:0] OUT_TMO  = 10'b00_0000_1001;

    exp5_unidade_controle #(.TIMEOUT_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .jogada_feita(jogada_feita), .igual(igual), .fimC(fimC), .fimT(fimT),
        .zeraC(zeraC), .contaC(contaC), .zeraT(zeraT), .contaT(contaT),
        .zeraR(zeraR), .registraR(registraR), .pronto(pronto),
        .acertou(acertou), .errou(errou), .timeout(timeout),
        .db_estado(db_estado)
    );

    exp5_unidade_controle #(.TIMEOUT_EN(1'b0)) dut_no_tmo (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .jogada_feita(jogada_feita), .igual(igual), .fimC(fimC), .fimT(fimT),
        .zeraC(n_zeraC), .contaC(n_contaC), .zeraT(n_zeraT), .contaT(n_contaT),
        .zeraR(n_zeraR), .registraR(n_registraR), .pronto(n_pronto),
        .acertou(n_acertou), .errou(n_errou), .timeout(n_timeout),
        .db_estado(n_db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (contaC) countC <= countC + 1;
    end

    function automatic logic [9:0] outVec();
        return {zeraC, contaC, zeraT, contaT, zeraR, registraR,
                pronto, acertou, errou, timeout};
    endfunction

    task automatic checkOutput(input string tag, input logic [9:0] got, input logic [9:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic ini, input logic jog, input logic ig,
                                 input logic fc, input logic ft);
        iniciar      = ini;
        jogada_feita = jog;
        igual        = ig;
        fimC         = fc;
        fimT         = ft;
        @(negedge clock);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic startGame();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
    endtask

    // One play from espera_jogada through comparacao; leaves DUT in the decision state.
    task automatic doPlay(input logic ig, input logic fc);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, ig, fc, 0);
        applyStimulus(0, 0, ig, fc, 0);
    endtask

    initial begin
        reset = 1'b0;
        iniciar = 0; jogada_feita = 0; igual = 0; fimC = 0; fimT = 0;
        @(negedge clock);

        doReset();
        checkOutput("reset_state", {6'd0, db_estado}, 10'h0);
        checkOutput("reset_outputs", outVec(), OUT_NONE);

        // Full win, with step-by-step checks on the first play
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("prep_state", {6'd0, db_estado}, 10'h1);
        checkOutput("prep_outputs", outVec(), OUT_PREP);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("espera_state", {6'd0, db_estado}, 10'h2);
        checkOutput("espera_outputs", outVec(), OUT_ESP);
        snapC = countC;
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("registra_state", {6'd0, db_estado}, 10'h4);
        checkOutput("registra_outputs", outVec(), OUT_REG);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("comparacao_state", {6'd0, db_estado}, 10'h5);
        checkOutput("comparacao_outputs", outVec(), OUT_NONE);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("proximo_state", {6'd0, db_estado}, 10'h6);
        checkOutput("proximo_outputs", outVec(), OUT_PROX);
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 1; i < 16; i++) begin
            doPlay(1'b1, i == 15);
            if (i != 15) applyStimulus(0, 0, 0, 0, 0);
        end
        checkOutput("win_state", {6'd0, db_estado}, 10'hA);
        checkOutput("win_outputs", outVec(), OUT_ACE);
        checkOutput("win_contaC_count", 10'(countC - snapC), 10'd15);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("win_hold", {6'd0, db_estado}, 10'hA);

        // Error on third play
        doReset();
        startGame();
        snapC = countC;
        doPlay(1'b1, 1'b0); applyStimulus(0, 0, 0, 0, 0);
        doPlay(1'b1, 1'b0); applyStimulus(0, 0, 0, 0, 0);
        doPlay(1'b0, 1'b0);
        checkOutput("err_state", {6'd0, db_estado}, 10'hE);
        checkOutput("err_outputs", outVec(), OUT_ERR);
        checkOutput("err_contaC_count", 10'(countC - snapC), 10'd2);

        // Restart from fim_erro
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("restart_state", {6'd0, db_estado}, 10'h1);
        checkOutput("restart_outputs", outVec(), OUT_PREP);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("restart_espera", {6'd0, db_estado}, 10'h2);

        // iniciar ignored mid-game
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("iniciar_ignored", {6'd0, db_estado}, 10'h2);

        // Timeout, with TIMEOUT_EN=0 instance staying in espera_jogada
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("tmo_state", {6'd0, db_estado}, 10'hD);
        checkOutput("tmo_outputs", outVec(), OUT_TMO);
        checkOutput("tmo_disabled_state", {6'd0, n_db_estado}, 10'h2);
        checkOutput("tmo_disabled_contaT", {9'd0, n_contaT}, 10'd1);

        // Simultaneous jogada_feita and fimT
        doReset();
        startGame();
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("simult_state", {6'd0, db_estado}, 10'h4);

        // Reset while in comparacao
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("midreset_pre", {6'd0, db_estado}, 10'h5);
        doReset();
        checkOutput("midreset_state", {6'd0, db_estado}, 10'h0);
        checkOutput("midreset_outputs", outVec(), OUT_NONE);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("idle_hold", {6'd0, db_estado}, 10'h0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("midreset_prep", outVec(), OUT_PREP);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
